// File: rtl/traffic_request_detector.sv
// rtl/traffic_request_detector.sv - per-lane detector sync, debounce and request latch; optional starve alarm (TRAFFIC_STARVE_ALARM_EN)
module traffic_request_detector #(
    parameter int LANES           = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STARVE_CYCLES   = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LANES-1:0] det_raw,
    input  logic [LANES-1:0] green_in,
    output logic [LANES-1:0] traffic,
    output logic [LANES-1:0] present,
    output logic [LANES-1:0] starve
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        L_IDLE  = 2'b00,
        L_WAIT  = 2'b01,
        L_SERVE = 2'b10
    } lane_state_e;

    logic [LANES-1:0]          sync1_q;
    logic [LANES-1:0]          sync2_q;
    logic [LANES-1:0]          present_q;
    logic [LANES-1:0]          present_d;
    logic [LANES-1:0]          traffic_q;
    logic [LANES-1:0]          traffic_d;
    logic [LANES-1:0]          rise;
    logic [LANES-1:0][CW-1:0]  cnt_q;
    logic [LANES-1:0][CW-1:0]  cnt_d;
    lane_state_e               state_q [LANES];
    lane_state_e               state_d [LANES];

    // Debounce: present follows s2 only after it has differed for DEBOUNCE_CYCLES cycles
    always_comb begin
        present_d = present_q;
        rise      = '0;
        cnt_d     = '0;
        for (int i = 0; i < LANES; i++) begin
            if (sync2_q[i] != present_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    present_d[i] = sync2_q[i];
                    rise[i]      = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Lane FSM next state: service beats arrival; release from service re-arms if a car is still present
    always_comb begin
        traffic_d = '0;
        for (int i = 0; i < LANES; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                L_IDLE: begin
                    if (green_in[i])  state_d[i] = L_SERVE;
                    else if (rise[i]) state_d[i] = L_WAIT;
                end
                L_WAIT: begin
                    if (green_in[i]) state_d[i] = L_SERVE;
                end
                L_SERVE: begin
                    if (!green_in[i]) state_d[i] = present_q[i] ? L_WAIT : L_IDLE;
                end
                default: state_d[i] = L_IDLE;
            endcase
            traffic_d[i] = (state_d[i] == L_WAIT);
        end
    end

    // Synchroniser, debounce and lane state registers; traffic is registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            present_q <= '0;
            traffic_q <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < LANES; i++) state_q[i] <= L_IDLE;
        end else begin
            sync1_q   <= det_raw;
            sync2_q   <= sync1_q;
            present_q <= present_d;
            traffic_q <= traffic_d;
            cnt_q     <= cnt_d;
            for (int i = 0; i < LANES; i++) state_q[i] <= state_d[i];
        end
    end

    assign traffic = traffic_q;
    assign present = present_q;

`ifdef TRAFFIC_STARVE_ALARM_EN
    localparam int            SW       = $clog2(STARVE_CYCLES + 1);
    localparam logic [SW-1:0] WAIT_MAX = SW'(STARVE_CYCLES);
    localparam logic [SW-1:0] WAIT_ONE = SW'(1);

    logic [LANES-1:0][SW-1:0] wcnt_q;
    logic [LANES-1:0][SW-1:0] wcnt_d;
    logic [LANES-1:0]         starve_q;
    logic [LANES-1:0]         starve_d;

    // Wait timer counts cycles spent in L_WAIT, saturating; anything else (incl. entering service) clears it
    always_comb begin
        wcnt_d   = '0;
        starve_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (state_q[i] == L_WAIT && state_d[i] == L_WAIT) begin
                wcnt_d[i] = (wcnt_q[i] == WAIT_MAX) ? WAIT_MAX : wcnt_q[i] + WAIT_ONE;
            end
            starve_d[i] = (wcnt_d[i] == WAIT_MAX);
        end
    end

    // Wait timer and starve flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q   <= '0;
            starve_q <= '0;
        end else begin
            wcnt_q   <= wcnt_d;
            starve_q <= starve_d;
        end
    end

    assign starve = starve_q;
`else
    assign starve = '0;
`endif

endmodule

// File: tb/tb_traffic_request_detector.sv
// tb/tb_traffic_request_detector.sv - scoreboard bench for traffic_request_detector with a behavioural lane model
module tb_traffic_request_detector;
    localparam int DEB    = 4;
    localparam int STARVE = 20;
`ifdef TRAFFIC_STARVE_ALARM_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] det_raw = 4'b0000;
    logic [3:0] green_in = 4'b0000;
    logic [3:0] traffic;
    logic [3:0] present;
    logic [3:0] starve;

    traffic_request_detector #(
        .LANES(4),
        .DEBOUNCE_CYCLES(DEB),
        .STARVE_CYCLES(STARVE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .det_raw(det_raw),
        .green_in(green_in),
        .traffic(traffic),
        .present(present),
        .starve(starve)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // expected {traffic, present, starve} per clock edge
    logic [11:0] exp_q [$];

    // behavioural model: raw samples, debounced level, run length, request and service flags
    bit [3:0] m_s1, m_s2, m_pres, m_req, m_serv;
    int       m_run  [4];
    int       m_wait [4];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_pres = 0; m_req = 0; m_serv = 0;
        for (int i = 0; i < 4; i++) begin
            m_run[i]  = 0;
            m_wait[i] = 0;
        end
    endtask

    task automatic model_step(input logic [3:0] det, input logic [3:0] grn);
        bit old_pres, rise, was_wait;
        for (int i = 0; i < 4; i++) begin
            old_pres = m_pres[i];
            was_wait = m_req[i];
            rise     = 1'b0;
            if (m_s2[i] != m_pres[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_pres[i] = m_s2[i];
                    m_run[i]  = 0;
                    rise      = m_s2[i];
                end
            end else begin
                m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = det[i];
            if (grn[i]) begin
                m_serv[i] = 1'b1;
                m_req[i]  = 1'b0;
            end else if (m_serv[i]) begin
                m_serv[i] = 1'b0;
                m_req[i]  = old_pres;
            end else if (rise) begin
                m_req[i] = 1'b1;
            end
            if (m_req[i] && was_wait) m_wait[i] = (m_wait[i] >= STARVE) ? STARVE : m_wait[i] + 1;
            else                      m_wait[i] = 0;
        end
    endtask

    function automatic logic [3:0] model_starve();
        logic [3:0] s;
        for (int i = 0; i < 4; i++) s[i] = STARVE_ON && (m_wait[i] == STARVE);
        return s;
    endfunction

    // one clock edge of stimulus; expectation for that edge goes to the scoreboard
    task automatic drive(input logic [3:0] det, input logic [3:0] grn);
        @(negedge clk);
        rst_n    = 1'b1;
        det_raw  = det;
        green_in = grn;
        @(posedge clk);
        model_step(det, grn);
        exp_q.push_back({m_req, m_pres, model_starve()});
    endtask

    // asynchronous reset between edges; outputs must clear without a clock edge
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n   = 1'b0;
        det_raw = 4'b1111;
        #1;
        check({tag, "_traffic"}, traffic, 4'b0000);
        check({tag, "_present"}, present, 4'b0000);
        check({tag, "_starve"},  starve,  4'b0000);
        model_reset();
        repeat (2) @(posedge clk);
        det_raw = 4'b0000;
    endtask

    // monitor: compare every scheduled expectation just after its edge
    initial begin
        logic [11:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_traffic", traffic, e[11:8]);
                check("sb_present", present, e[7:4]);
                check("sb_starve",  starve,  e[3:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] det, grn;
        int ghold;
        model_reset();

        // reset with detectors active, no clock edge
        #1;
        rst_n    = 1'b0;
        det_raw  = 4'b1111;
        green_in = 4'b0000;
        #1;
        check("reset_traffic", traffic, 4'b0000);
        check("reset_present", present, 4'b0000);
        check("reset_starve",  starve,  4'b0000);
        det_raw = 4'b0000;

        // glitch of three cycles is discarded
        repeat (3) drive(4'b0001, 4'b0000);
        repeat (8) drive(4'b0000, 4'b0000);
        #2;
        check("glitch_present", present, 4'b0000);
        check("glitch_traffic", traffic, 4'b0000);

        // arrival latency: visible after the sixth edge, not the fifth
        repeat (5) drive(4'b0100, 4'b0000);
        #2;
        check("arrive5_traffic", traffic, 4'b0000);
        drive(4'b0100, 4'b0000);
        #2;
        check("arrive6_traffic", traffic, 4'b0100);
        check("arrive6_present", present, 4'b0100);
        repeat (10) drive(4'b0000, 4'b0000);
        #2;
        check("latched_traffic", traffic, 4'b0100);
        check("latched_present", present, 4'b0000);

        // service and re-arm
        repeat (8) drive(4'b0101, 4'b0000);
        #2;
        check("svc_pre_traffic", traffic, 4'b0101);
        drive(4'b0101, 4'b0101);
        #2;
        check("svc_on_traffic", traffic, 4'b0000);
        drive(4'b0101, 4'b0000);
        #2;
        check("rearm_traffic", traffic, 4'b0101);
        repeat (8) drive(4'b0000, 4'b0000);
        drive(4'b0000, 4'b0101);
        drive(4'b0000, 4'b0000);
        #2;
        check("svc_clear_traffic", traffic, 4'b0000);

        // collision: present rises on the same edge as green
        repeat (5) drive(4'b0010, 4'b0000);
        drive(4'b0010, 4'b0010);
        #2;
        check("coll_traffic", traffic, 4'b0000);
        check("coll_present", present, 4'b0010);
        repeat (3) drive(4'b0010, 4'b0010);
        #2;
        check("coll_green_traffic", traffic, 4'b0000);
        drive(4'b0010, 4'b0000);
        #2;
        check("coll_after_traffic", traffic, 4'b0010);

        // reset while a request is waiting
        do_reset("midwait");

        // starve timing on lane 3
        repeat (6) drive(4'b1000, 4'b0000);
        repeat (19) drive(4'b1000, 4'b0000);
        #2;
        check("starve19", starve, 4'b0000);
        drive(4'b1000, 4'b0000);
        #2;
        check("starve20", starve, STARVE_ON ? 4'b1000 : 4'b0000);
        drive(4'b1000, 4'b1000);
        #2;
        check("starve_served", starve, 4'b0000);

        // randomized traffic with held green phases and occasional resets
        det   = 4'b0000;
        grn   = 4'b0000;
        ghold = 0;
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) det[i] = ~det[i];
            if (ghold == 0) begin
                grn   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'b0000;
                ghold = $urandom_range(1, 30);
            end else begin
                ghold--;
            end
            if ($urandom_range(0, 499) == 0) do_reset("rand_reset");
            else                             drive(det, grn);
        end

        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
